ftdi_tx_arbiter: RTL

- Shares the FTDI FIFO transmit write port (TxData/TxEn/TxFull) between pNumReq on-chip byte-stream producers, e.g. DMM measurement channels and the status reporter.
- Arbitrates round-robin, then frames each grant as one packet: 2-byte header, payload, optional XOR trailer.
- Sits on the 48 MHz system clock directly in front of the FIFO TX input, so all traffic to the host is serialized without software collisions.

---
 rtl/ftdi_tx_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter
//   Shares the FTDI FIFO transmit write port between pNumReq byte-stream
//   producers. A round-robin arbiter picks one requester at a time, and each
//   grant is sent as a single packet:
//     {4'hA, channel} , length , payload[0..length-1] [, xor trailer]
//   A length of 0 gives a header-only packet.
//
//   Optional feature (macro FTDI_ARB_CHKSUM_EN): after the payload, a TRAIL
//   byte is appended. It holds the XOR of every header and payload byte. The
//   length field in the header does not count the trailer.
//
// Ports
//   iClk      system clock (48 MHz)
//   iRst_n    asynchronous active-low reset
//   iReq      per-requester packet request (level, held until granted)
//   iReqLen   packed payload lengths, slice k -> requester k
//   iData     packed show-ahead payload bytes, slice k -> requester k
//   oGnt      one-hot grant, held for the whole packet
//   oDataAck  one-cycle pop strobe to the granted requester per payload byte
//   oTxData   byte to the FIFO TX input
//   oTxEn     FIFO write strobe (never asserted while iTxFull is high)
//   iTxFull   FIFO full
//   oBusy     packet in progress
//   oPktDone  pulses on the cycle the last byte of a packet is written
module ftdi_tx_arbiter #(
  parameter int pNumReq    = 4,
  parameter int pDataWidth = 8,
  parameter int pLenWidth  = 8
) (
  input  logic                            iClk,
  input  logic                            iRst_n,
  input  logic [pNumReq-1:0]              iReq,
  input  logic [pNumReq*pLenWidth-1:0]    iReqLen,
  input  logic [pNumReq*pDataWidth-1:0]   iData,
  output logic [pNumReq-1:0]              oGnt,
  output logic [pNumReq-1:0]              oDataAck,
  output logic [7:0]                      oTxData,
  output logic                            oTxEn,
  input  logic                            iTxFull,
  output logic                            oBusy,
  output logic                            oPktDone
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD
`ifdef FTDI_ARB_CHKSUM_EN
    , TRAIL
`endif
  } tState;

  tState                  state, stateNext;
  logic [3:0]             chan;       // latched channel index of the grant
  logic [3:0]             ptr;        // last granted requester
  logic [pLenWidth-1:0]   len;        // latched payload length
  logic [pLenWidth-1:0]   cnt;        // payload bytes already written
  logic [pLenWidth-1:0]   lenLast;
  logic [pNumReq-1:0]     reqRot;
  logic [4:0]             rotAmt;
  logic                   anyReq;
  logic [3:0]             win;
  logic [pLenWidth-1:0]   winLen;
  logic [7:0]             payByte;
  int                     off;
  int                     pos;
`ifdef FTDI_ARB_CHKSUM_EN
  logic [7:0]             chk;
`endif

  assign lenLast = len - pLenWidth'(1);

  // Round-robin pick. The request vector is rotated so that bit 0 is the
  // requester right after the pointer. The lowest set bit is then the
  // winner, counted as an offset from pointer+1.
  always_comb begin : arbSel
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    rotAmt = {1'b0, ptr} + 5'd1;
    reqRot = pNumReq'({iReq, iReq} >> rotAmt);
    anyReq = |iReq;
    off    = 0;
    for (int i = pNumReq - 1; i >= 0; i--) begin
      if (reqRot[i]) off = i;
    end
    pos = int'(ptr) + 1 + off;
    if (pos >= pNumReq) pos = pos - pNumReq;
    win    = 4'(pos);
    winLen = '0;
    for (int k = 0; k < pNumReq; k++) begin
      if (win == 4'(k)) winLen = iReqLen[k*pLenWidth +: pLenWidth];
    end
  end

  // Show-ahead byte of the granted requester, passed straight through.
  always_comb begin : paySel
    payByte = '0;
    for (int k = 0; k < pNumReq; k++) begin
      if (chan == 4'(k)) payByte = iData[k*pDataWidth +: 8];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin : stateReg
    // NOTE: all sequential state uses non-blocking assignments. Every
    // register then samples pre-edge values, whatever order the blocks run in.
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state and outputs. A byte is consumed only on an edge where oTxEn
  // is high, so each transition below is gated by oTxEn. While iTxFull
  // stalls the packet, the state and oTxData hold.
  always_comb begin : fsmComb
    stateNext = state;
    oBusy     = (state != IDLE);
    oTxEn     = (state != IDLE) && !iTxFull;
    oTxData   = '0;
    oDataAck  = '0;
    oPktDone  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) stateNext = HDR0;
      end
      HDR0: begin
        oTxData = {4'hA, chan};
        if (oTxEn) stateNext = HDR1;
      end
      HDR1: begin
        oTxData = 8'(len);
        if (oTxEn) begin
          if (len == '0) begin
`ifdef FTDI_ARB_CHKSUM_EN
            stateNext = TRAIL;
`else
            stateNext = IDLE;
            oPktDone  = 1'b1;
`endif
          end else begin
            stateNext = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        oTxData  = payByte;
        oDataAck = oTxEn ? oGnt : '0;
        if (oTxEn && cnt == lenLast) begin
`ifdef FTDI_ARB_CHKSUM_EN
          stateNext = TRAIL;
`else
          stateNext = IDLE;
          oPktDone  = 1'b1;
`endif
        end
      end
`ifdef FTDI_ARB_CHKSUM_EN
      TRAIL: begin
        oTxData = chk;
        if (oTxEn) begin
          stateNext = IDLE;
          oPktDone  = 1'b1;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // Grant, latched request fields, pointer and payload counter. Request
  // inputs are looked at only in IDLE, so changes after the grant have no
  // effect on the packet in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin : dataReg
    if (!iRst_n) begin
      oGnt <= '0;
      chan <= '0;
      len  <= '0;
      cnt  <= '0;
      ptr  <= 4'(pNumReq - 1);
`ifdef FTDI_ARB_CHKSUM_EN
      chk  <= '0;
`endif
    end else begin
      if (state == IDLE && anyReq) begin
        oGnt <= pNumReq'(1) << win;
        chan <= win;
        len  <= winLen;
        ptr  <= win;
        cnt  <= '0;
      end
      if (state == PAYLOAD && oTxEn) cnt <= cnt + pLenWidth'(1);
      if (state != IDLE && stateNext == IDLE) oGnt <= '0;
`ifdef FTDI_ARB_CHKSUM_EN
      if (state == IDLE) chk <= '0;
      else if (oTxEn && state inside {HDR0, HDR1, PAYLOAD}) chk <= chk ^ oTxData;
`endif
    end
  end

endmodule
